// File: rtl/auto_defuser.sv
// Binary-search solver for the time-bomb game: finds secret A (4b) then B (3b) from comparison hints.
// Issues one enter strobe per guess, paced by WAIT_CYCLES; all outputs registered; abort forces FAIL.
module auto_defuser #(
  parameter int WAIT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] hint_cmp,
  output logic [3:0] guess_a,
  output logic [2:0] guess_b,
  output logic       enter,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] attempts
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_A_PRESENT, S_A_WAIT, S_A_EVAL,
    S_B_PRESENT, S_B_WAIT, S_B_EVAL, S_DONE, S_FAIL
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_lo, r_hi, w_lo_nxt, w_hi_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    w_guess_a_nxt, w_att_nxt, w_guess, w_mid;
  logic [2:0]    w_guess_b_nxt;
  logic [4:0]    w_sum;
  logic          w_phase_b, w_busy_state, w_busy_nxt;

  assign w_phase_b    = (r_state == S_B_PRESENT) || (r_state == S_B_WAIT) || (r_state == S_B_EVAL);
  assign w_guess      = w_phase_b ? {1'b0, guess_b} : guess_a;
  assign w_busy_state = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_FAIL);
  assign w_busy_nxt   = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) && (w_state_nxt != S_FAIL);

  always_comb begin
    w_state_nxt   = r_state;
    w_lo_nxt      = r_lo;
    w_hi_nxt      = r_hi;
    w_cnt_nxt     = r_cnt;
    w_att_nxt     = attempts;
    w_guess_a_nxt = guess_a;
    w_guess_b_nxt = guess_b;
    w_sum         = 5'd0;
    w_mid         = 4'd0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_lo_nxt    = 4'd0;
          w_hi_nxt    = 4'd15;
          w_att_nxt   = 4'd0;
          w_state_nxt = S_A_PRESENT;
        end
      end
      S_A_PRESENT, S_B_PRESENT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = w_phase_b ? S_B_WAIT : S_A_WAIT;
      end
      S_A_WAIT, S_B_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CW'(WAIT_CYCLES - 1))
          w_state_nxt = w_phase_b ? S_B_EVAL : S_A_EVAL;
      end
      S_A_EVAL, S_B_EVAL: begin
        case (hint_cmp)
          2'b00: begin
            if (w_phase_b) begin
              w_state_nxt = S_DONE;
            end else begin
              w_lo_nxt    = 4'd0;
              w_hi_nxt    = 4'd7;
              w_state_nxt = S_B_PRESENT;
            end
          end
          2'b01: begin
            if (w_guess == r_hi) begin
              w_state_nxt = S_FAIL;
            end else begin
              w_lo_nxt    = w_guess + 4'd1;
              w_state_nxt = w_phase_b ? S_B_PRESENT : S_A_PRESENT;
            end
          end
          2'b10: begin
            if (w_guess == r_lo) begin
              w_state_nxt = S_FAIL;
            end else begin
              w_hi_nxt    = w_guess - 4'd1;
              w_state_nxt = w_phase_b ? S_B_PRESENT : S_A_PRESENT;
            end
          end
          default: w_state_nxt = S_FAIL;
        endcase
      end
      S_DONE:  w_state_nxt = S_DONE;
      S_FAIL:  w_state_nxt = S_FAIL;
      default: w_state_nxt = S_FAIL;
    endcase

    // Abort overrides every decision above, so no enter follows it.
    if (abort && w_busy_state)
      w_state_nxt = S_FAIL;

    // Guess is formed from the bounds that take effect on PRESENT entry.
    w_sum = {1'b0, w_lo_nxt} + {1'b0, w_hi_nxt};
    w_mid = w_sum[4:1];
    if (w_state_nxt == S_A_PRESENT || w_state_nxt == S_B_PRESENT) begin
      if (w_att_nxt != 4'd15)
        w_att_nxt = w_att_nxt + 4'd1;
      if (w_state_nxt == S_A_PRESENT)
        w_guess_a_nxt = w_mid;
      else
        w_guess_b_nxt = w_mid[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_lo     <= 4'd0;
      r_hi     <= 4'd0;
      r_cnt    <= '0;
      guess_a  <= 4'd0;
      guess_b  <= 3'd0;
      enter    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      attempts <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_cnt    <= w_cnt_nxt;
      guess_a  <= w_guess_a_nxt;
      guess_b  <= w_guess_b_nxt;
      enter    <= (w_state_nxt == S_A_PRESENT) || (w_state_nxt == S_B_PRESENT);
      busy     <= w_busy_nxt;
      done     <= (w_state_nxt == S_DONE);
      fail     <= (w_state_nxt == S_FAIL);
      attempts <= w_att_nxt;
    end
  end

endmodule

// File: tb/tb_auto_defuser.sv
// Directed bench for auto_defuser: a small game-core model answers hints from registered attempts.
module tb_auto_defuser;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] hint_cmp;
  logic [3:0] guess_a, attempts;
  logic [2:0] guess_b;
  logic       enter, busy, done, fail;

  auto_defuser #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .hint_cmp(hint_cmp),
    .guess_a(guess_a), .guess_b(guess_b), .enter(enter), .busy(busy),
    .done(done), .fail(fail), .attempts(attempts)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Game-core model: latches the attempt on each enter and compares against the secret.
  int         sec_a = 0, sec_b = 0;
  bit         force_en = 0;
  logic [1:0] force_val = 2'b00;
  logic [3:0] att_a = 4'd0;
  logic [2:0] att_b = 3'd0;
  bit         a_locked = 0, b_mode = 0;
  int         ga_log[$], gb_log[$], en_cyc[$];
  int         cyc = 0, n_enter = 0;

  function automatic logic [1:0] cmp(input int s, input int a);
    if (s == a) return 2'b00;
    if (s > a)  return 2'b01;
    return 2'b10;
  endfunction

  always_comb begin
    hint_cmp = 2'b00;
    if (force_en)    hint_cmp = force_val;
    else if (b_mode) hint_cmp = cmp(sec_b, int'(att_b));
    else             hint_cmp = cmp(sec_a, int'(att_a));
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      a_locked = 0; b_mode = 0; att_a = 4'd0; att_b = 3'd0; n_enter = 0;
      ga_log.delete(); gb_log.delete(); en_cyc.delete();
    end else if (enter) begin
      n_enter++;
      en_cyc.push_back(cyc);
      if (a_locked) begin
        b_mode = 1;
        att_b  = guess_b;
        gb_log.push_back(int'(guess_b));
      end else begin
        att_a = guess_a;
        ga_log.push_back(int'(guess_a));
        if (int'(att_a) == sec_a) a_locked = 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int hit;
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      if (done || fail) begin
        hit = 1;
        break;
      end
      tick();
    end
    check_eq({tag, "_finished"}, hit, 1);
  endtask

  task automatic check_seq(input string tag, input int got[$], input int exp[$]);
    check_eq({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check_eq($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic run_solve(input int sa, input int sb, input bit fe, input logic [1:0] fv, input string tag);
    sec_a = sa; sec_b = sb; force_en = fe; force_val = fv;
    do_reset();
    pulse_start();
    wait_end(tag);
  endtask

  initial begin
    int n;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check_eq("reset_outputs", {guess_a, guess_b, enter, busy, done, fail, attempts}, 0);
    reset = 1'b0;

    // A=7, B=3: first guesses hit both secrets
    sec_a = 7; sec_b = 3; force_en = 0;
    do_reset();
    pulse_start();
    check_eq("t1_first_guess_a", guess_a, 7);
    check_eq("t1_first_enter", enter, 1);
    check_eq("t1_first_busy", busy, 1);
    check_eq("t1_first_attempts", attempts, 1);
    tick();
    check_eq("t1_enter_one_cycle", enter, 0);
    wait_end("t1");
    check_eq("t1_done", done, 1);
    check_eq("t1_fail", fail, 0);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_attempts", attempts, 2);
    check_seq("t1_ga", ga_log, '{7});
    check_seq("t1_gb", gb_log, '{3});
    if (en_cyc.size() >= 2) check_eq("t1_enter_spacing", en_cyc[1] - en_cyc[0], W + 2);
    else check_eq("t1_enter_count", en_cyc.size(), 2);
    check_eq("t1_guess_a_held", guess_a, 7);
    check_eq("t1_guess_b_final", guess_b, 3);

    // A=15, B=7: upper edge of both ranges
    run_solve(15, 7, 0, 2'b00, "t2");
    check_eq("t2_done", done, 1);
    check_eq("t2_attempts", attempts, 9);
    check_seq("t2_ga", ga_log, '{7, 11, 13, 14, 15});
    check_seq("t2_gb", gb_log, '{3, 5, 6, 7});

    // A=0, B=0: lower edge of both ranges
    run_solve(0, 0, 0, 2'b00, "t3");
    check_eq("t3_done", done, 1);
    check_eq("t3_attempts", attempts, 7);
    check_seq("t3_ga", ga_log, '{7, 3, 1, 0});
    check_seq("t3_gb", gb_log, '{3, 1, 0});

    // Invalid hint at the first evaluation
    run_solve(7, 3, 1, 2'b11, "t4");
    check_eq("t4_fail", fail, 1);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_done", done, 0);
    repeat (10) tick();
    check_eq("t4_no_more_enter", n_enter, 1);

    // "secret smaller" once the guess has reached lo
    run_solve(0, 0, 1, 2'b10, "t5");
    check_eq("t5_fail", fail, 1);
    check_eq("t5_attempts", attempts, 4);
    check_seq("t5_ga", ga_log, '{7, 3, 1, 0});

    // Abort during B_WAIT
    sec_a = 7; sec_b = 3; force_en = 0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 50 && gb_log.size() == 0; i++) tick();
    check_eq("t6_reached_b", gb_log.size(), 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t6_fail", fail, 1);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_enter", enter, 0);
    n = n_enter;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      tick();
    end
    start = 1'b0;
    check_eq("t6_no_enter_after", n_enter, n);
    check_eq("t6_fail_held", fail, 1);
    check_eq("t6_done", done, 0);
    check_eq("t6_attempts", attempts, 2);

    // Reset during A_WAIT, then a fresh solve
    sec_a = 15; sec_b = 7;
    do_reset();
    pulse_start();
    tick();
    check_eq("t7_in_wait_busy", busy, 1);
    reset = 1'b1;
    tick();
    check_eq("t7_reset_outputs", {guess_a, guess_b, enter, busy, done, fail, attempts}, 0);
    reset = 1'b0;
    tick();
    check_eq("t7_idle_no_enter", enter, 0);
    pulse_start();
    check_eq("t7_restart_guess_a", guess_a, 7);
    check_eq("t7_restart_attempts", attempts, 1);
    check_eq("t7_restart_enter", enter, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
